// File: rtl/fir_high.sv
// Stereo FIR engine: one 16x16 MAC per channel per streamed sample, Q15 result on run end.
// Define FIR_SAT_EN to saturate the Q15 result instead of wrapping.
module fir_high #(
    parameter int NTAPS = 1021
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sequencing,
    input  logic signed [15:0] lft_in,
    input  logic signed [15:0] rght_in,
    input  logic signed [15:0] coef,
    output logic        [9:0]  coef_addr,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [9:0]  LAST_ADDR  = 10'(NTAPS - 1);
    localparam logic [9:0]  FIRST_ADDR = (NTAPS > 1) ? 10'd1 : 10'd0;
    localparam logic [10:0] NTAPS_CNT  = 11'(NTAPS);

    state_t             state_r;
    logic signed [31:0] acc_lft_r;
    logic signed [31:0] acc_rght_r;
    logic        [10:0] mac_cnt_r;
    logic               seq_d_r;
    logic signed [15:0] smpl_lft_r;
    logic signed [15:0] smpl_rght_r;
    logic signed [31:0] prod_lft_s;
    logic signed [31:0] prod_rght_s;

    // Q15 scaling of the 32-bit accumulator, optionally clamped at the rails.
    function automatic logic signed [15:0] scale_result(input logic signed [31:0] acc);
        logic signed [15:0] res;
`ifdef FIR_SAT_EN
        case (acc[31:30])
            2'b01:   res = 16'sh7FFF;
            2'b10:   res = 16'sh8000;
            default: res = acc[30:15];
        endcase
`else
        res = acc[30:15];
`endif
        return res;
    endfunction

    // Per-channel signed products of the delayed sample and the ROM coefficient.
    always_comb begin
        prod_lft_s  = 32'(smpl_lft_r) * 32'(coef);
        prod_rght_s = 32'(smpl_rght_r) * 32'(coef);
    end

    // Run sequencer, ROM address generator, accumulators and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            coef_addr   <= 10'd0;
            lft_out     <= 16'sd0;
            rght_out    <= 16'sd0;
            valid       <= 1'b0;
            acc_lft_r   <= 32'sd0;
            acc_rght_r  <= 32'sd0;
            mac_cnt_r   <= 11'd0;
            seq_d_r     <= 1'b0;
            smpl_lft_r  <= 16'sd0;
            smpl_rght_r <= 16'sd0;
        end else begin
            // Samples are delayed one cycle to line up with the ROM read latency.
            seq_d_r     <= sequencing;
            smpl_lft_r  <= lft_in;
            smpl_rght_r <= rght_in;
            valid       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sequencing) begin
                        state_r    <= ACCUM;
                        acc_lft_r  <= 32'sd0;
                        acc_rght_r <= 32'sd0;
                        mac_cnt_r  <= 11'd0;
                        coef_addr  <= FIRST_ADDR;
                    end else begin
                        coef_addr  <= 10'd0;
                    end
                end
                ACCUM: begin
                    if (sequencing && (coef_addr != LAST_ADDR)) begin
                        coef_addr <= coef_addr + 10'd1;
                    end else begin
                        coef_addr <= coef_addr;
                    end
                    if (seq_d_r) begin
                        if (mac_cnt_r < NTAPS_CNT) begin
                            acc_lft_r  <= acc_lft_r + prod_lft_s;
                            acc_rght_r <= acc_rght_r + prod_rght_s;
                            mac_cnt_r  <= mac_cnt_r + 11'd1;
                        end else begin
                            mac_cnt_r  <= mac_cnt_r;
                        end
                    end else begin
                        state_r  <= DONE;
                        lft_out  <= scale_result(acc_lft_r);
                        rght_out <= scale_result(acc_rght_r);
                        valid    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    coef_addr <= 10'd0;
                    mac_cnt_r <= 11'd0;
                end
                default: begin
                    state_r   <= IDLE;
                    coef_addr <= 10'd0;
                    mac_cnt_r <= 11'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_high.sv
// Scoreboard bench for fir_high: random and directed runs against a dot-product model.
module tb_fir_high;

    localparam int NTAPS = 1021;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sequencing;
    logic signed [15:0] lft_in;
    logic signed [15:0] rght_in;
    logic signed [15:0] coef;
    logic        [9:0]  coef_addr;
    logic signed [15:0] lft_out;
    logic signed [15:0] rght_out;
    logic               valid;

    logic signed [15:0] rom [0:1023];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [15:0] l;
        logic signed [15:0] r;
        int                 end_cyc;
    } exp_t;
    exp_t exp_q[$];

    fir_high #(.NTAPS(NTAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sequencing(sequencing),
        .lft_in    (lft_in),
        .rght_in   (rght_in),
        .coef      (coef),
        .coef_addr (coef_addr),
        .lft_out   (lft_out),
        .rght_out  (rght_out),
        .valid     (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // External synchronous coefficient ROM.
    always @(posedge clk) coef <= rom[coef_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Dot product of the first min(n, NTAPS) samples with the ROM, wrapped to 32 bits, Q15 out.
    function automatic logic signed [15:0] model(input logic signed [15:0] s[$], input int n);
        longint      sum;
        logic [63:0] s64;
        logic [31:0] acc;
        int          m;
        sum = 0;
        m = (n < NTAPS) ? n : NTAPS;
        for (int k = 0; k < m; k++) sum += longint'(s[k]) * longint'(rom[k]);
        s64 = sum;
        acc = s64[31:0];
`ifdef FIR_SAT_EN
        if (acc[31:30] == 2'b01) return 16'sh7FFF;
        if (acc[31:30] == 2'b10) return 16'sh8000;
`endif
        return acc[30:15];
    endfunction

    // mode: 0 random, 1 left impulse, 2 DC 0x0100, 3 full-scale 0x7FFF
    task automatic do_run(input int n, input int mode, input bit gap, input int tail);
        logic signed [15:0] ls[$];
        logic signed [15:0] rs[$];
        logic signed [15:0] l;
        logic signed [15:0] r;
        int   peak;
        int   last;
        exp_t e;
        peak = 0;
        last = 0;
        for (int k = 0; k < n; k++) begin
            case (mode)
                1:       begin l = (k == 0) ? 16'sh4000 : 16'sh0000; r = 16'($urandom); end
                2:       begin l = 16'sh0100; r = 16'sh0100; end
                3:       begin l = 16'sh7FFF; r = 16'sh7FFF; end
                default: begin l = 16'($urandom); r = 16'($urandom); end
            endcase
            ls.push_back(l);
            rs.push_back(r);
            sequencing = 1'b1;
            lft_in     = l;
            rght_in    = r;
            @(negedge clk);
            if (int'(coef_addr) > peak) peak = int'(coef_addr);
            last = cyc;
            @(posedge clk); #1;
        end
        sequencing = 1'b0;
        lft_in     = 16'($urandom);
        rght_in    = 16'($urandom);
        e.l = model(ls, n);
        e.r = model(rs, n);
        e.end_cyc = last;
        exp_q.push_back(e);
        if (gap) begin
            @(posedge clk); #1;
            sequencing = 1'b1;
            @(posedge clk); #1;
            sequencing = 1'b0;
        end
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            if (int'(coef_addr) > peak) peak = int'(coef_addr);
            @(posedge clk); #1;
        end
        if (!gap) chk("coef_addr_peak", peak, (n < NTAPS - 1) ? n : NTAPS - 1);
        chk("coef_addr_idle", coef_addr, 0);
    endtask

    // Monitor: pop expected result on every valid pulse and check value and latency.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (valid) begin
                    chk("valid_single_cycle", prev, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("lft_out", lft_out, e.l);
                        chk("rght_out", rght_out, e.r);
                        chk("latency", cyc - e.end_cyc, 3);
                    end
                end
                prev = valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        sequencing = 1'b0;
        lft_in     = 16'sd0;
        rght_in    = 16'sd0;
        for (int k = 0; k < 1024; k++) rom[k] = 16'sd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_coef_addr", coef_addr, 0);
        chk("reset_lft_out", lft_out, 0);
        chk("reset_rght_out", rght_out, 0);
        chk("reset_valid", valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 1024; k++) rom[k] = 16'($urandom);
        rom[0] = 16'sh2000;
        do_run(NTAPS, 1, 1'b0, 4);

        for (int k = 0; k < 1024; k++) rom[k] = 16'sh0010;
        do_run(NTAPS, 2, 1'b0, 4);

        for (int k = 0; k < 1024; k++) rom[k] = 16'sh7FFF;
        do_run(NTAPS, 3, 1'b0, 4);

        for (int k = 0; k < 1024; k++) rom[k] = 16'($urandom);
        do_run(1030, 0, 1'b0, 4);

        do_run(300, 0, 1'b0, 3);
        do_run(57, 0, 1'b0, 4);
        do_run(200, 0, 1'b1, 4);
        do_run(1, 0, 1'b0, 4);
        do_run(2, 0, 1'b0, 4);
        repeat (3) do_run(int'($urandom_range(1030, 3)), 0, 1'b0, 4);

        // Abort a run with reset part-way through accumulation.
        for (int k = 0; k < 400; k++) begin
            sequencing = 1'b1;
            lft_in     = 16'($urandom);
            rght_in    = 16'($urandom);
            @(posedge clk); #1;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_rst_coef_addr", coef_addr, 0);
        chk("midrun_rst_lft_out", lft_out, 0);
        chk("midrun_rst_rght_out", rght_out, 0);
        chk("midrun_rst_valid", valid, 0);
        sequencing = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_valid", valid, 0);
            chk("post_rst_coef_addr", coef_addr, 0);
        end
        @(posedge clk); #1;

        do_run(100, 0, 1'b0, 4);
        repeat (5) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
